// File: rtl/prog_sequence_detector.sv
// Programmable symbol-sequence detector.
// Keeps a shift history of the last N valid symbols and compares it with a
// loadable pattern. A match gives a registered one-cycle pulse and bumps a
// saturating counter. OVERLAP selects whether history survives a match.
module prog_sequence_detector #(
    parameter int W = 2,
    parameter int N = 4,
    parameter int CW = 4,
    parameter bit OVERLAP = 1'b1,
    parameter logic [N*W-1:0] PATTERN = (N*W)'(8'b00_01_10_11)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [W-1:0]   x,
    input  logic           valid,
    input  logic           pat_load,
    input  logic [N*W-1:0] pat_in,
    input  logic           clear_count,
    output logic           match,
    output logic [CW-1:0]  count
);

    // The fill counter must be able to hold the value N itself.
    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);

    logic [N*W-1:0] pattern;
    logic [N*W-1:0] hist;
    logic [N*W-1:0] hist_shift;
    logic [FW-1:0]  fill;
    logic [FW-1:0]  fill_inc;
    logic [FW-1:0]  fill_next;
    logic           hit;

    // The newest symbol enters at the LSB end, so the oldest symbol sits in the
    // MSB slot and lines up with the first pattern symbol.
    always_comb begin
        hist_shift = {hist[N*W-W-1:0], x};
        fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
        // A pattern load in the same cycle swallows the incoming symbol.
        hit        = valid && !pat_load && (fill_inc == FILL_FULL) &&
                     (hist_shift == pattern);
        fill_next  = fill;
        if (pat_load) begin
            fill_next = '0;
        end else if (valid) begin
            if (hit && (OVERLAP == 1'b0)) begin
                fill_next = '0;
            end else begin
                fill_next = fill_inc;
            end
        end
    end

    // Pattern register, symbol history and fill level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern <= PATTERN;
            hist    <= '0;
            fill    <= '0;
        end else begin
            if (pat_load) begin
                pattern <= pat_in;
            end
            if (valid && !pat_load) begin
                hist <= hist_shift;
            end
            fill <= fill_next;
        end
    end

    // Match pulse and saturating detection counter; clear wins over increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            match <= 1'b0;
            count <= '0;
        end else begin
            match <= hit;
            if (clear_count) begin
                count <= '0;
            end else if (hit && (count != {CW{1'b1}})) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule
